// File: rtl/motor_input_conditioner_if.sv
// Raw switch inputs and conditioned outputs between the board
// pins and the motor up/down controller.
interface motor_input_conditioner_if;
  logic btn_raw;
  logic up_limit_raw;
  logic dn_limit_raw;
  logic activate;
  logic up_limit;
  logic dn_limit;
  logic fault;

  modport master (
    output btn_raw,
    output up_limit_raw,
    output dn_limit_raw,
    input  activate,
    input  up_limit,
    input  dn_limit,
    input  fault
  );

  modport slave (
    input  btn_raw,
    input  up_limit_raw,
    input  dn_limit_raw,
    output activate,
    output up_limit,
    output dn_limit,
    output fault
  );
endinterface

// File: rtl/motor_input_conditioner.sv
// Synchronise and debounce the button and limit switches, and turn
// each clean press into one activate pulse with lockout and fault gating.
module motor_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 64
) (
  input logic clk,
  input logic rst_n,
  motor_input_conditioner_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW =
    (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_INIT =
    LW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    HOLD
  } state_t;

  // bit 2 = button, bit 1 = upper limit, bit 0 = lower limit
  logic [2:0] raw;
  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] lvl;

  assign raw = {bus.btn_raw,
                bus.up_limit_raw,
                bus.dn_limit_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_db
    logic [CW-1:0] cnt_q;
    logic          lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (s2[g] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        lvl_q <= s2[g];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign lvl[g] = lvl_q;
  end

  logic btn_db;
  logic up_db;
  logic dn_db;
  logic fault_q;

  assign btn_db = lvl[2];
  assign up_db  = lvl[1];
  assign dn_db  = lvl[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= up_db & dn_db;
  end

  state_t        state;
  state_t        state_n;
  logic [LW-1:0] lock;
  logic [LW-1:0] lock_n;
  logic          act_q;

  // A press seen during a fault is consumed by going straight to HOLD
  always_comb begin
    state_n = state;
    lock_n  = lock;
    unique case (state)
      IDLE: begin
        if (btn_db) state_n = fault_q ? HOLD : FIRE;
      end
      FIRE: begin
        lock_n  = LOCK_INIT;
        state_n = HOLD;
      end
      HOLD: begin
        if (lock != '0)  lock_n  = lock - 1'b1;
        else if (!btn_db) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lock  <= '0;
      act_q <= 1'b0;
    end else begin
      state <= state_n;
      lock  <= lock_n;
      act_q <= (state_n == FIRE);
    end
  end

  assign bus.activate = act_q;
  assign bus.up_limit = up_db;
  assign bus.dn_limit = dn_db;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_motor_input_conditioner.sv
// Segment-table bench for motor_input_conditioner; expected
// outputs are queued per edge and checked just after each edge.
module tb_motor_input_conditioner;

  localparam int D = 4;
  localparam int L = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  motor_input_conditioner_if bus ();

  motor_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LOCKOUT_CYCLES (L)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string nm;
    logic  btn;
    logic  up;
    logic  dn;
    int    n;
    int    act_at;
    int    lim_at;
    int    flt_at;
    logic  f1;
  } seg_t;

  typedef struct {
    string      nm;
    int         k;
    logic [3:0] v;
  } exp_t;

  exp_t sb[$];
  seg_t segs[$];
  int   tests = 0;
  int   fails = 0;
  logic cu = 1'b0;
  logic cd = 1'b0;
  logic cf = 1'b0;

  function automatic logic [3:0] outs();
    return {bus.activate, bus.up_limit,
            bus.dn_limit, bus.fault};
  endfunction

  task automatic chk(string nm, int k,
                     logic [3:0] got,
                     logic [3:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s edge %0d: act/up/dn/flt got %b required %b",
               nm, k, got, req);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, e.k, outs(), e.v);
    end
  end

  task automatic add(string nm, logic btn, logic up,
                     logic dn, int n, int act_at,
                     int lim_at, int flt_at, logic f1);
    seg_t s;
    s.nm = nm; s.btn = btn; s.up = up; s.dn = dn;
    s.n = n; s.act_at = act_at; s.lim_at = lim_at;
    s.flt_at = flt_at; s.f1 = f1;
    segs.push_back(s);
  endtask

  // Edge k=1 is the first edge sampling this segment's inputs
  task automatic run_seg(seg_t s);
    for (int k = 1; k <= s.n; k++) begin
      bus.btn_raw      = s.btn;
      bus.up_limit_raw = s.up;
      bus.dn_limit_raw = s.dn;
      if (k == s.lim_at) begin
        cu = s.up;
        cd = s.dn;
      end
      if (k == s.flt_at) cf = s.f1;
      sb.push_back('{s.nm, k,
                     {(k == s.act_at), cu, cd, cf}});
      @(negedge clk);
    end
  endtask

  initial begin
    seg_t s;
    bus.btn_raw      = 1'b0;
    bus.up_limit_raw = 1'b0;
    bus.dn_limit_raw = 1'b0;

    //   name        btn up dn  n  act lim flt f1
    add("idle",       0, 0, 0, 20, 0, 0, 0, 0);
    add("hold_press", 1, 0, 0, 30, 7, 0, 0, 0);
    add("release",    0, 0, 0, 20, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add("bounce", 1'((i + 1) % 2), 0, 0, 2, 0, 0, 0, 0);
    add("glitch",     1, 0, 0,  3, 0, 0, 0, 0);
    add("settle",     0, 0, 0, 10, 0, 0, 0, 0);
    add("press_a",    1, 0, 0,  9, 7, 0, 0, 0);
    add("rel_short",  0, 0, 0,  2, 0, 0, 0, 0);
    add("repress",    1, 0, 0, 20, 0, 0, 0, 0);
    add("rel_a",      0, 0, 0, 12, 0, 0, 0, 0);
    add("press_b",    1, 0, 0, 15, 7, 0, 0, 0);
    add("rel_b",      0, 0, 0, 20, 0, 0, 0, 0);
    add("limits",     0, 1, 1, 12, 0, 6, 7, 1);
    add("press_flt",  1, 1, 1, 20, 0, 0, 0, 0);
    add("dn_drop",    1, 1, 0, 20, 0, 6, 7, 0);
    add("rel_c",      0, 1, 0, 12, 0, 0, 0, 0);
    add("press_c",    1, 1, 0, 15, 7, 0, 0, 0);
    add("rel_all",    0, 0, 0, 20, 0, 6, 0, 0);

    repeat (3) @(negedge clk);
    chk("reset", 0, outs(), 4'b0000);
    rst_n = 1'b1;

    foreach (segs[i]) run_seg(segs[i]);

    // Async reset mid-lockout: lock is 5 after edge 11
    s = '{"press_d", 1, 1, 0, 11, 7, 6, 0, 0};
    run_seg(s);
    chk("pre_rst_up", 0, outs(), 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 0, outs(), 4'b0000);
    cu = 1'b0;
    cd = 1'b0;
    cf = 1'b0;
    @(negedge clk);
    chk("in_rst", 0, outs(), 4'b0000);
    rst_n = 1'b1;
    s = '{"post_rst", 1, 1, 0, 12, 7, 6, 0, 0};
    run_seg(s);
    s = '{"rel_d", 0, 0, 0, 24, 0, 6, 0, 0};
    run_seg(s);

    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d left required 0",
               sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
